// File: rtl/clock_display.sv
`default_nettype none
// ============================================================================
// Module   : clock_display
// Purpose  : Multiplexed 4-digit 7-segment driver for an HH:MM alarm clock,
//            with colon blink, alarm flash and invalid-time dashes.
//            Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
// Revision : 1.0 - initial release
// ============================================================================
module clock_display #(
    parameter int SCAN_DIV   = 2,
    parameter int BLINK_HALF = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Clock,
    input  logic        Alarm,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int c_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_BLINK_W = $clog2(2 * BLINK_HALF);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_HALF = c_BLINK_W'(BLINK_HALF);
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

    logic [15:0]          r_clock;
    logic [15:0]          r_snap;
    logic                 r_alarm;
    logic                 r_alarm_q;
    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]           r_slot;
    logic [c_BLINK_W-1:0] r_blink;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic        w_slot_start;
    logic [15:0] w_time;
    logic [1:0]  w_digit;
    logic [3:0]  w_nibble;
    logic        w_valid;
    logic        w_rise;
    logic        w_on;
    logic [6:0]  w_seg;
    logic        w_dp;

    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        case (n)
            4'd0:    f_seg7 = 7'b1000000;
            4'd1:    f_seg7 = 7'b1111001;
            4'd2:    f_seg7 = 7'b0100100;
            4'd3:    f_seg7 = 7'b0110000;
            4'd4:    f_seg7 = 7'b0011001;
            4'd5:    f_seg7 = 7'b0010010;
            4'd6:    f_seg7 = 7'b0000010;
            4'd7:    f_seg7 = 7'b1111000;
            4'd8:    f_seg7 = 7'b0000000;
            4'd9:    f_seg7 = 7'b0010000;
            default: f_seg7 = 7'h7F;
        endcase
    endfunction

    // A slot latches the time on its first cycle so mid-slot changes wait for the next digit
    assign w_slot_start = (r_scan_cnt == '0);
    assign w_time       = w_slot_start ? r_clock : r_snap;
    assign w_digit      = 2'd3 - r_slot;
    assign w_rise       = r_alarm & ~r_alarm_q;
    assign w_on         = w_rise | (r_blink < c_BLINK_HALF);

    always_comb begin
        w_nibble = w_time[3:0];
        case (w_digit)
            2'd3:    w_nibble = w_time[15:12];
            2'd2:    w_nibble = w_time[11:8];
            2'd1:    w_nibble = w_time[7:4];
            default: w_nibble = w_time[3:0];
        endcase
    end

    always_comb begin
        w_valid = (w_time[3:0] <= 4'd9) && (w_time[7:4] <= 4'd5) &&
                  (w_time[11:8] <= 4'd9) &&
                  ((w_time[15:12] < 4'd2) ||
                   ((w_time[15:12] == 4'd2) && (w_time[11:8] <= 4'd3)));
    end

    always_comb begin
        w_seg = f_seg7(w_nibble);
        w_dp  = 1'b1;
        if (!w_valid) begin
            w_seg = c_SEG_DASH;
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if ((w_digit == 2'd3) && (w_nibble == 4'd0)) begin
                w_seg = c_SEG_BLANK;
            end
`endif
            if (r_alarm && !w_on) begin
                w_seg = c_SEG_BLANK;
            end
            if ((w_digit == 2'd2) && (r_alarm || w_on)) begin
                w_dp = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clock    <= '0;
            r_snap     <= '0;
            r_alarm    <= 1'b0;
            r_alarm_q  <= 1'b0;
            r_scan_cnt <= '0;
            r_slot     <= '0;
            r_blink    <= '0;
            r_an       <= 4'b1111;
            r_seg      <= c_SEG_BLANK;
            r_dp       <= 1'b1;
        end else begin
            r_clock   <= Clock;
            r_alarm   <= Alarm;
            r_alarm_q <= r_alarm;
            if (w_slot_start) begin
                r_snap <= r_clock;
            end
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_slot     <= r_slot + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            // The rising-edge cycle itself is blink index 0, so continue from 1
            if (w_rise) begin
                r_blink <= c_BLINK_W'(1);
            end else if (r_blink == c_BLINK_LAST) begin
                r_blink <= '0;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
            r_an  <= ~(4'b0001 << w_digit);
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_clock_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_display
// Purpose  : Self-checking bench for clock_display against a cycle-level
//            reference model derived from the display rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_display;

    localparam int SD = 2;
    localparam int BH = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] t_clock = 16'h0000;
    logic        t_alarm = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // Reference state: cycles since release, cycles since last alarm rise
    int          m_n = 0;
    int          m_since = 0;
    logic [15:0] m_clk_reg = 16'h0000;
    logic [15:0] m_snap = 16'h0000;
    logic        m_alarm_reg = 1'b0;
    logic        m_alarm_prev = 1'b0;
    logic [11:0] m_exp = 12'hFFF;

    clock_display #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
        .clk   (clk),
        .reset (reset),
        .Clock (t_clock),
        .Alarm (t_alarm),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [11:0] expect_out(input logic [15:0] t, input int digit,
                                               input logic alarm, input logic on);
        int ht, hu, mt, mu, nib;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        ht  = int'(t[15:12]);
        hu  = int'(t[11:8]);
        mt  = int'(t[7:4]);
        mu  = int'(t[3:0]);
        nib = int'((t >> (4 * digit)) & 16'h000F);
        a = 4'b1111;
        a[digit] = 1'b0;
        d = 1'b1;
        if (ht > 9 || hu > 9 || mt > 9 || mu > 9 || (ht * 10 + hu) > 23 || (mt * 10 + mu) > 59) begin
            s = 7'b0111111;
        end else begin
            s = seg_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
            if (digit == 3 && nib == 0) s = 7'h7F;
`endif
            if (alarm && !on) s = 7'h7F;
            if (digit == 2 && (alarm || on)) d = 1'b0;
        end
        return {a, s, d};
    endfunction

    task automatic model_edge();
        int digit;
        logic on;
        if (reset) begin
            m_exp = {4'b1111, 7'h7F, 1'b1};
            m_n = 0;
            m_since = 0;
            m_clk_reg = 16'h0000;
            m_alarm_reg = 1'b0;
            m_alarm_prev = 1'b0;
        end else begin
            if (m_n % SD == 0) m_snap = m_clk_reg;
            digit = 3 - ((m_n / SD) % 4);
            if (m_alarm_reg && !m_alarm_prev) m_since = 0;
            on = (m_since % (2 * BH)) < BH;
            m_exp = expect_out(m_snap, digit, m_alarm_reg, on);
            m_n++;
            m_since++;
            m_alarm_prev = m_alarm_reg;
            m_clk_reg = t_clock;
            m_alarm_reg = t_alarm;
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk_eq("out", {4'h0, an, seg, dp}, {4'h0, m_exp});
        end
    endtask

    function automatic logic [15:0] rand_time();
        logic [3:0] ht, hu, mt, mu;
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        ht = 4'($urandom_range(0, 2));
        hu = (ht == 4'd2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
        mt = 4'($urandom_range(0, 5));
        mu = 4'($urandom_range(0, 9));
        return {ht, hu, mt, mu};
    endfunction

    initial begin : main
        logic [6:0] want;
        logic       found;

        // Reset state
        cyc(3);
        chk_eq("rst_an", {12'h0, an}, 16'h000F);
        chk_eq("rst_seg", {9'h0, seg}, 16'h007F);
        chk_eq("rst_dp", {15'h0, dp}, 16'h0001);

        // Steady 12:32 with colon blink
        reset = 1'b0;
        t_clock = 16'h1232;
        cyc(10);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            case (an)
                4'b0111: want = 7'b1111001;
                4'b1011: want = 7'b0100100;
                4'b1101: want = 7'b0110000;
                default: want = 7'b0100100;
            endcase
            chk_eq("d1232", {9'h0, seg}, {9'h0, want});
            chk_eq("dp1232", {15'h0, dp}, {15'h0, ~(an == 4'b1011)});
        end
        cyc(1100);

        // Alarm flash on 13:08, then release
        t_clock = 16'h1308;
        cyc(20);
        t_alarm = 1'b1;
        cyc(1100);
        t_alarm = 1'b0;
        cyc(20);

        // Invalid times dash regardless of alarm
        t_clock = 16'h2360;
        cyc(50);
        chk_eq("dash2360", {9'h0, seg}, 16'h003F);
        t_alarm = 1'b1;
        cyc(700);
        chk_eq("dash_alarm", {9'h0, seg}, 16'h003F);
        t_clock = 16'h1A00;
        cyc(50);
        chk_eq("dash1A00", {9'h0, seg}, 16'h003F);

        // Leading zero 09:05, alarm off
        t_alarm = 1'b0;
        t_clock = 16'h0905;
        cyc(40);

        // Reset mid-scan while flashing
        t_alarm = 1'b1;
        cyc(13);
        reset = 1'b1;
        cyc(1);
        chk_eq("midrst", {4'h0, an, seg, dp}, 16'h0FFF);
        reset = 1'b0;
        cyc(1);
        chk_eq("first_dig", {12'h0, an}, 16'h0007);
        t_alarm = 1'b0;
        cyc(20);

        // 23:59 -> 00:00 arriving during the digit-1 slot
        t_clock = 16'h2359;
        cyc(10);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (an == 4'b1101 && m_n % SD == 1) found = 1'b1;
        end
        chk_eq("sync_d1", {15'h0, found}, 16'h0001);
        t_clock = 16'h0000;
        cyc(1);
        chk_eq("d1_hold", {4'h0, an, seg, 1'b0}, {4'h0, 4'b1101, 7'b0010010, 1'b0});
        cyc(1);
        chk_eq("d0_new", {4'h0, an, seg, 1'b0}, {4'h0, 4'b1110, 7'b1000000, 1'b0});
        cyc(10);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) t_clock = rand_time();
            if ($urandom_range(0, 299) == 0) t_alarm = ~t_alarm;
            reset = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_display.md
CLOCK_DISPLAY -- requirements
Module: clock_display

Interface
- REQ-001 Parameter SCAN_DIV, default 2: clk cycles each digit stays selected (≥1).
- REQ-002 Parameter BLINK_HALF, default 500: clk cycles per blink half-period (0.5 s at the 1 ms clk).
- REQ-003 Port clk, input, 1: single system clock, rising edge, 1 ms period.
- REQ-004 Port reset, input, 1: synchronous, active-high.
- REQ-005 Port Clock, input, 16: BCD time HH:MM from the alarm clock, [15:12] hours tens down to [3:0] minutes units.
- REQ-006 Port Alarm, input, 1: alarm-active level from the alarm clock.
- REQ-007 Port an, output, 4: digit enables, active-low one-hot; an[3] = hours tens … an[0] = minutes units.
- REQ-008 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- REQ-009 Port dp, output, 1: colon/decimal point, active-low, driven only while an[2] is selected.

Function
- REQ-010 Clock and Alarm SHALL be registered every cycle; a changed value SHALL first appear on seg/an 2 cycles after the input edge.
- REQ-011 Scan counter SHALL select digit 3,2,1,0 in that order, each for SCAN_DIV cycles, then wrap 0→3.
- REQ-012 an, seg and dp SHALL all be registered and change only together, with no cycle driving two digits.
- REQ-013 Blink counter SHALL run 0..2*BLINK_HALF-1 and wrap; cycles 0..BLINK_HALF-1 are the on-phase.
- REQ-014 Any BCD nibble >9, hours >23 or minutes >59 SHALL show all four digits as dash (seg=7'b0111111), with the colon off.
- REQ-015 Digits 0-9 SHALL use standard 7-segment encoding, for example 0 = 7'b1000000 and 8 = 7'b0000000.
- REQ-016 Alarm low: the colon (dp low on digit 2) SHALL be lit in the on-phase and dark in the off-phase, with digits steady.
- REQ-017 Alarm high: the colon SHALL be lit continuously, and all segments SHALL blank (seg=7'h7F) in the off-phase while an keeps scanning.
- REQ-018 An Alarm rising edge SHALL reset the blink counter to 0, so flashing starts in the on-phase.
- REQ-019 An Alarm falling edge SHALL restore steady digits within 2 cycles, and the blink counter SHALL continue without reset.
- REQ-020 A Clock change mid-scan SHALL take effect on the next digit slot, not retroactively.
- REQ-021 Invalid-time dashing (REQ-014) SHALL take priority over alarm flashing.

Reset
- REQ-022 With reset high at a clk edge: an=4'b1111, seg=7'h7F, dp=1, scan and blink counters 0, registered Clock = 16'h0000 and registered Alarm = 0.
- REQ-023 Reset SHALL override all activity, including mid-scan and mid-flash, and the first digit after release SHALL be digit 3.

Configuration
- REQ-024 With macro LEADING_ZERO_BLANK_EN defined, hours tens = 0 SHALL display blank (seg=7'h7F) on digit 3.
- REQ-025 Without LEADING_ZERO_BLANK_EN, hours tens = 0 SHALL display as "0" (seg=7'b1000000).

Verification
- REQ-026 Clock=16'h1232, Alarm=0 → scan shows 1,2,3,2, each for 2 cycles; dp low on an[2] for 500 cycles, then high for 500 cycles.
- REQ-027 Clock=16'h1308, then Alarm rising → colon steady; seg=7'h7F for cycles 500..999 after the edge; digits return ≤2 cycles after Alarm falls.
- REQ-028 Clock=16'h2360 or 16'h1A00 → all digits dash, colon off; dashes persist when Alarm is high.
- REQ-029 Clock=16'h0905 → digit 3 blank with LEADING_ZERO_BLANK_EN, "0" without it.
- REQ-030 Assert reset mid-scan with Alarm high → next cycle an=4'b1111, seg=7'h7F, dp=1; after release, digit 3 comes first.
- REQ-031 Clock 16'h2359→16'h0000 while digit 1 is selected → digit 1 keeps its old value for the rest of its slot; all digits show the new value from the next slot on.
